memory_bus_responder: RTL

- SDRAM-side responder for the slot memory bus: accepts level-style requests (addr, rnw, data, ram_cs) issued by the slot/mapper logic.
- Converts each distinct access into one req/ack transaction toward the SDRAM controller and returns registered read data.
- Keeps a one-entry read cache so repeated reads of the same address, held while ram_cs is high, do not re-hit SDRAM.
- Sits between the slot block's memory bus output and the SDRAM controller port.

---
 rtl/memory_bus_responder_pkg.sv | 24 ++
 rtl/memory_bus_responder_if.sv | 33 +++
 rtl/memory_bus_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/memory_bus_responder_pkg.sv
// Shared types for the SDRAM-side memory bus responder: FSM states,
// read-cache entry and bus widths.
package memory_bus_responder_pkg;

  localparam int unsigned MEM_ADDR_W  = 27;
  localparam int unsigned MEM_DATA_W  = 8;
  localparam int unsigned MEM_TIMEOUT = 255;

  // Read data returned when nothing valid has been fetched (reset, timeout).
  localparam logic [MEM_DATA_W-1:0] MEM_Q_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } mem_resp_state_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic                  valid;
  } rd_cache_t;

endpackage

// File: rtl/memory_bus_responder_if.sv
// Memory-bus request side plus SDRAM controller port of the responder.
// slave = the responder; master = slot logic and SDRAM controller together.
interface memory_bus_responder_if #(
  parameter int unsigned ADDR_W = memory_bus_responder_pkg::MEM_ADDR_W
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rnw;
  logic [7:0]        mem_data;
  logic              mem_ram_cs;
  logic [7:0]        mem_q;
  logic              mem_busy;

  logic              sdram_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_we;
  logic [7:0]        sdram_din;
  logic              sdram_ack;
  logic [7:0]        sdram_dout;

  logic              timeout_err;

  modport slave (
    input  mem_addr, mem_rnw, mem_data, mem_ram_cs, sdram_ack, sdram_dout,
    output mem_q, mem_busy, sdram_req, sdram_addr, sdram_we, sdram_din, timeout_err
  );

  modport master (
    output mem_addr, mem_rnw, mem_data, mem_ram_cs, sdram_ack, sdram_dout,
    input  mem_q, mem_busy, sdram_req, sdram_addr, sdram_we, sdram_din, timeout_err
  );

endinterface

// File: rtl/memory_bus_responder.sv
// Turns level-style memory bus accesses into single SDRAM req/ack transactions,
// with a one-entry read cache and a sticky timeout flag.
module memory_bus_responder
  import memory_bus_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned TIMEOUT = MEM_TIMEOUT
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  memory_bus_responder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mem_resp_state_t   r_state;
  rd_cache_t         r_cache;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [7:0]        r_din;
  logic              r_req;
  logic              r_busy;
  logic [7:0]        r_q;
  logic              r_err;
  logic [ADDR_W-1:0] r_hold_addr;
  logic              r_hold_rnw;

  logic              w_rd_hit;
  logic              w_wr_hit;
  logic              w_changed;
  logic              w_start;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_timeout;

  // Access decode: cache hits, changed access under a held cs, timeout reach.
  always_comb begin
    w_rd_hit  = bus.mem_ram_cs && bus.mem_rnw && r_cache.valid &&
                (r_cache.addr == MEM_ADDR_W'(bus.mem_addr));
    w_wr_hit  = r_cache.valid && (r_cache.addr == MEM_ADDR_W'(r_addr));
    w_changed = (bus.mem_rnw != r_hold_rnw) ||
                (bus.mem_rnw && (bus.mem_addr != r_hold_addr));
    w_cnt_inc = r_cnt + CNT_W'(1);
    w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));
    w_start   = 1'b0;
    case (r_state)
      IDLE:    w_start = bus.mem_ram_cs;
      HOLD:    w_start = bus.mem_ram_cs && w_changed;
      default: w_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cache     <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_din       <= '0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_q         <= MEM_Q_IDLE;
      r_err       <= 1'b0;
      r_hold_addr <= '0;
      r_hold_rnw  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_start) begin
            r_hold_addr <= bus.mem_addr;
            r_hold_rnw  <= bus.mem_rnw;
            if (w_rd_hit) begin
              r_q     <= r_cache.data;
              r_state <= HOLD;
            end else begin
              r_addr  <= bus.mem_addr;
              r_we    <= ~bus.mem_rnw;
              r_din   <= bus.mem_data;
              r_req   <= 1'b1;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_state <= REQ;
            end
          end else if (!bus.mem_ram_cs) begin
            r_state <= IDLE;
          end
        end

        // Ack has priority over a timeout reached in the same cycle.
        REQ: begin
          if (bus.sdram_ack) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= HOLD;
            if (!r_we) begin
              r_q     <= bus.sdram_dout;
              r_cache <= '{addr: MEM_ADDR_W'(r_addr), data: bus.sdram_dout, valid: 1'b1};
            end else if (w_wr_hit) begin
              r_cache.data <= r_din;
            end
          end else if (w_timeout) begin
            r_err         <= 1'b1;
            r_q           <= MEM_Q_IDLE;
            r_cache.valid <= 1'b0;
            r_req         <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= HOLD;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_q       = r_q;
  assign bus.mem_busy    = r_busy;
  assign bus.sdram_req   = r_req;
  assign bus.sdram_addr  = r_addr;
  assign bus.sdram_we    = r_we;
  assign bus.sdram_din   = r_din;
  assign bus.timeout_err = r_err;

endmodule
